// File: rtl/ahb_split_mem.sv
// AHB slave memory with split-transaction support: unlocked NONSEQ reads are split,
// fetched after a fixed delay, then released to the requesting master via HSPLIT.
//
// state  | meaning
// S_IDLE | no split outstanding
// S_WAIT | split accepted, fetch delay counting down
// S_DONE | HSPLIT issued, waiting for the split master to re-read sadr
module ahb_split_mem #(
   parameter int P_SLV_ID        = 0,
   parameter int P_SIZE_IN_BYTES = 1024,
   parameter int P_SPLIT_DELAY   = 4
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [31:0] HWDATA,
   input  logic [3:0]  HMASTER,
   input  logic        HMASTLOCK,
   input  logic        HREADYin,
   output logic [31:0] HRDATA,
   output logic [1:0]  HRESP,
   output logic        HREADYout,
   output logic [15:0] HSPLIT
);

   localparam int AW     = $clog2(P_SIZE_IN_BYTES);
   localparam int WW     = AW - 2;
   localparam int NWORDS = P_SIZE_IN_BYTES / 4;

   localparam logic [1:0] R_OKAY  = 2'd0;
   localparam logic [1:0] R_ERROR = 2'd1;
   localparam logic [1:0] R_RETRY = 2'd2;
   localparam logic [1:0] R_SPLIT = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [3:0]      smst_q, smst_d;
   logic [WW-1:0]   sadr_q, sadr_d;
   logic [1:0]      resp_q, resp_d;
   logic            ready_q, ready_d;
   logic            cyc2_q, cyc2_d;
   logic [15:0]     hsplit_q, hsplit_d;
   logic            wr_q, wr_d;
   logic            rd_q, rd_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [1:0]      size_q, size_d;

   logic [31:0]     mem [NWORDS];
   logic [3:0]      strb;
   logic            accept, misalign, same_req, split_rd, two;
   logic [1:0]      code;
   logic [WW-1:0]   addr_word;
   logic            unused_ok;

   assign unused_ok = ^{HBURST, HADDR[31:AW], P_SLV_ID != 0};

   // transfers presented during either cycle of a two-cycle response are ignored
   assign accept    = HSEL & HREADYin & HTRANS[1] & ready_q & ~cyc2_q;
   assign misalign  = (HSIZE > 3'd2) || (HSIZE == 3'd1 && HADDR[0]) ||
                      (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);
   assign addr_word = HADDR[AW-1:2];
   assign same_req  = (HMASTER == smst_q) && (addr_word == sadr_q);
   assign split_rd  = ~HWRITE & (HTRANS == 2'b10) & ~HMASTLOCK;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      smst_d   = smst_q;
      sadr_d   = sadr_q;
      resp_d   = R_OKAY;
      ready_d  = 1'b1;
      cyc2_d   = 1'b0;
      hsplit_d = '0;
      wr_d     = 1'b0;
      rd_d     = 1'b0;
      addr_d   = addr_q;
      size_d   = size_q;
      code     = R_OKAY;
      two      = 1'b0;

      if (state_q == S_WAIT && cnt_q != 8'd0) begin
         cnt_d = cnt_q - 8'd1;
         if (cnt_q == 8'd1) begin
            hsplit_d = 16'd1 << smst_q;
            state_d  = S_DONE;
         end
      end

      if (!ready_q) begin
         resp_d = resp_q;
         cyc2_d = 1'b1;
      end else if (accept) begin
         addr_d = HADDR[AW-1:0];
         size_d = HSIZE[1:0];
         if (misalign) begin
            code = R_ERROR;
            two  = 1'b1;
         end else if (HWRITE) begin
            wr_d = 1'b1;
         end else if (!split_rd) begin
            rd_d = 1'b1;
         end else begin
            case (state_q)
               S_IDLE: begin
                  code    = R_SPLIT;
                  two     = 1'b1;
                  smst_d  = HMASTER;
                  sadr_d  = addr_word;
                  cnt_d   = 8'(P_SPLIT_DELAY);
                  state_d = S_WAIT;
               end
               S_WAIT: begin
                  code = same_req ? R_SPLIT : R_RETRY;
                  two  = 1'b1;
               end
               default: begin
                  if (same_req) begin
                     rd_d    = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     code = R_RETRY;
                     two  = 1'b1;
                  end
               end
            endcase
         end
         if (two) begin
            ready_d = 1'b0;
            resp_d  = code;
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         smst_q   <= '0;
         sadr_q   <= '0;
         resp_q   <= R_OKAY;
         ready_q  <= 1'b1;
         cyc2_q   <= 1'b0;
         hsplit_q <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         addr_q   <= '0;
         size_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         smst_q   <= smst_d;
         sadr_q   <= sadr_d;
         resp_q   <= resp_d;
         ready_q  <= ready_d;
         cyc2_q   <= cyc2_d;
         hsplit_q <= hsplit_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         addr_q   <= addr_d;
         size_q   <= size_d;
      end
   end

   always_comb begin
      case (size_q)
         2'd0:    strb = 4'b0001 << addr_q[1:0];
         2'd1:    strb = addr_q[1] ? 4'b1100 : 4'b0011;
         default: strb = 4'b1111;
      endcase
   end

   // memory contents are deliberately not reset
   always_ff @(posedge HCLK) begin
      if (wr_q) begin
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) mem[addr_q[AW-1:2]][8*b +: 8] <= HWDATA[8*b +: 8];
         end
      end
   end

   assign HRDATA    = rd_q ? mem[addr_q[AW-1:2]] : 32'd0;
   assign HRESP     = resp_q;
   assign HREADYout = ready_q;
   assign HSPLIT    = hsplit_q;

endmodule

// File: tb/tb_ahb_split_mem.sv
// Scoreboard bench for ahb_split_mem: driver predicts each response from a byte-array
// memory and a split bookkeeping model; a negedge monitor compares responses and HSPLIT.
module tb_ahb_split_mem;

   localparam int D    = 4;
   localparam int SIZE = 1024;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        HSEL = 1'b0;
   logic [31:0] HADDR = '0;
   logic [1:0]  HTRANS = '0;
   logic        HWRITE = 1'b0;
   logic [2:0]  HSIZE = '0;
   logic [2:0]  HBURST = '0;
   logic [31:0] HWDATA = '0;
   logic [3:0]  HMASTER = '0;
   logic        HMASTLOCK = 1'b0;
   logic        HREADYin;
   logic [31:0] HRDATA;
   logic [1:0]  HRESP;
   logic        HREADYout;
   logic [15:0] HSPLIT;

   assign HREADYin = HREADYout;
   always #5 HCLK = ~HCLK;

   ahb_split_mem #(.P_SLV_ID(0), .P_SIZE_IN_BYTES(SIZE), .P_SPLIT_DELAY(D)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
      .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK), .HREADYin(HREADYin),
      .HRDATA(HRDATA), .HRESP(HRESP), .HREADYout(HREADYout), .HSPLIT(HSPLIT)
   );

   typedef struct {
      logic [1:0]  code;
      bit          two;
      bit          chk;
      logic [31:0] rdata;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   bit          dphase = 1'b0;
   bit          saw_wait = 1'b0;
   logic [7:0]  mem_m [SIZE];
   bit          pend = 1'b0;
   logic [3:0]  p_m = '0;
   int          p_word = 0;
   int          p_due = 0;
   int          hs_due = -1;
   logic [3:0]  hs_m = '0;

   always @(posedge HCLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] word_of(input int w);
      return {mem_m[w*4+3], mem_m[w*4+2], mem_m[w*4+1], mem_m[w*4]};
   endfunction

   always @(negedge HCLK) begin
      if (HRESETn)
         check("hsplit", {16'd0, HSPLIT}, (hs_due == cyc) ? {16'd0, 16'd1 << hs_m} : 32'd0);
      if (dphase) begin
         if (exp_q.size() == 0) begin
            check("unexpected_dphase", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q[0];
            if (!HREADYout) begin
               check("resp_cycle1", {30'd0, HRESP}, {30'd0, mon_e.code});
               saw_wait = 1'b1;
            end else begin
               check("wait_cycle", 32'(saw_wait), 32'(mon_e.two));
               check("resp", {30'd0, HRESP}, {30'd0, mon_e.code});
               if (mon_e.chk) check("rdata", HRDATA, mon_e.rdata);
               void'(exp_q.pop_front());
               saw_wait = 1'b0;
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge HCLK);
         #1;
      end
   endtask

   task automatic xfer(input bit sel, input logic [1:0] trans, input bit wr, input logic [2:0] size,
                       input logic [31:0] addr, input logic [3:0] m, input bit lock,
                       input logic [31:0] wdata);
      exp_t e;
      int   off, w, ln;
      bit   err, done;
      HSEL = sel; HTRANS = trans; HWRITE = wr; HSIZE = size; HADDR = addr;
      HMASTER = m; HMASTLOCK = lock; HBURST = 3'($urandom_range(0, 7));
      off = int'(addr[9:0]);
      w   = off / 4;
      err = (size > 3'd2) || (size == 3'd1 && off % 2 != 0) || (size == 3'd2 && off % 4 != 0);
      e.code = 2'd0; e.two = 1'b0; e.chk = 1'b0; e.rdata = '0;
      if (sel && trans[1]) begin
         if (err) begin
            e.code = 2'd1; e.two = 1'b1;
         end else if (wr) begin
            for (int b = 0; b < (1 << size); b++) begin
               ln = off % 4 + b;
               mem_m[w*4+ln] = wdata[8*ln +: 8];
            end
         end else if (trans == 2'b11 || lock) begin
            e.chk = 1'b1; e.rdata = word_of(w);
         end else if (!pend) begin
            e.code = 2'd3; e.two = 1'b1;
            pend = 1'b1; p_m = m; p_word = w; p_due = cyc + 1 + D;
            hs_due = p_due; hs_m = m;
         end else if (m == p_m && w == p_word) begin
            if (cyc < p_due) begin
               e.code = 2'd3; e.two = 1'b1;
            end else begin
               e.chk = 1'b1; e.rdata = word_of(w); pend = 1'b0;
            end
         end else begin
            e.code = 2'd2; e.two = 1'b1;
         end
      end
      exp_q.push_back(e);
      @(posedge HCLK);
      #1;
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = wdata; dphase = 1'b1;
      done = 1'b0;
      for (int n = 0; n < 4 && !done; n++) begin
         @(negedge HCLK);
         done = HREADYout;
      end
      if (!done) begin
         check("dphase_timeout", 32'd0, 32'd1);
         if (exp_q.size() != 0) void'(exp_q.pop_front());
         saw_wait = 1'b0;
      end
      @(posedge HCLK);
      #1;
      dphase = 1'b0;
   endtask

   task automatic release_and_reread();
      while (pend && cyc < p_due) idle(1);
      if (pend) xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'(p_word * 4), p_m, 1'b0, 32'd0);
   endtask

   initial begin
      logic [31:0] a, upper;
      logic [2:0]  sz;
      logic [1:0]  tr;
      int          r;

      idle(2);
      @(negedge HCLK);
      check("rst_hrdata", HRDATA, 32'd0);
      check("rst_hresp", {30'd0, HRESP}, 32'd0);
      check("rst_hready", 32'(HREADYout), 32'd1);
      check("rst_hsplit", {16'd0, HSPLIT}, 32'd0);
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      idle(1);

      for (int i = 0; i < 32; i++) xfer(1'b1, 2'b10, 1'b1, 3'd2, 32'(i * 4), 4'd0, 1'b0, $urandom());

      xfer(1'b1, 2'b10, 1'b1, 3'd2, 32'h10, 4'd0, 1'b0, 32'hA5A5_0001);
      xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 4'd0, 1'b1, 32'd0);
      xfer(1'b1, 2'b10, 1'b1, 3'd2, 32'h10, 4'd0, 1'b0, 32'h1122_3344);
      xfer(1'b1, 2'b10, 1'b1, 3'd0, 32'h13, 4'd0, 1'b0, 32'hFF00_0000);
      xfer(1'b1, 2'b11, 1'b0, 3'd2, 32'h10, 4'd0, 1'b0, 32'd0);
      check("byte_lane_model", word_of(4), 32'hFF22_3344);

      xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h20, 4'd2, 1'b0, 32'd0);
      xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h30, 4'd1, 1'b0, 32'd0);
      xfer(1'b1, 2'b10, 1'b1, 3'd2, 32'h34, 4'd1, 1'b0, 32'hCAFE_0034);
      xfer(1'b1, 2'b11, 1'b0, 3'd2, 32'h34, 4'd1, 1'b0, 32'd0);
      release_and_reread();

      xfer(1'b1, 2'b10, 1'b0, 3'd1, 32'h21, 4'd0, 1'b0, 32'd0);
      xfer(1'b1, 2'b10, 1'b1, 3'd1, 32'h21, 4'd0, 1'b0, 32'hDEAD_BEEF);
      xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h20, 4'd0, 1'b1, 32'd0);

      xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h40, 4'd3, 1'b0, 32'd0);
      HRESETn = 1'b0;
      pend = 1'b0;
      hs_due = -1;
      @(negedge HCLK);
      check("midrst_hsplit", {16'd0, HSPLIT}, 32'd0);
      check("midrst_hready", 32'(HREADYout), 32'd1);
      check("midrst_hresp", {30'd0, HRESP}, 32'd0);
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      idle(8);
      xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h44, 4'd5, 1'b0, 32'd0);
      release_and_reread();

      for (int i = 0; i < 300; i++) begin
         upper = $urandom() & 32'hFFFF_FC00;
         if (pend && $urandom_range(0, 3) == 0) begin
            xfer(1'b1, 2'b10, 1'b0, 3'd2, upper | 32'(p_word * 4), p_m, 1'b0, 32'd0);
         end else begin
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 127));
            if ($urandom_range(0, 4) != 0 && sz <= 3'd2) a = a & ~((32'd1 << sz) - 32'd1);
            r  = $urandom_range(0, 9);
            tr = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r < 4) ? 2'b11 : 2'b10;
            xfer($urandom_range(0, 19) != 0, tr, $urandom_range(0, 99) < 45, sz, upper | a,
                 4'($urandom_range(0, 3)), $urandom_range(0, 9) == 0, $urandom());
         end
      end
      release_and_reread();
      idle(D + 4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
